// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM state encoding, channel codes and default sample width.
package i2s_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StWait
  } i2s_state_e;

  localparam logic I2S_CH_LEFT  = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;

  localparam int unsigned I2S_SAMPLE_W = 16;

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronizes the codec bit clock, LR clock and ADC data into clk32 and flags bclk rising edges.
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk32,
  input  logic rst,
  input  logic bclk_i,
  input  logic lrclk_i,
  input  logic adcdat_i,
  output logic bclk_rise,
  output logic lr_s,
  output logic dat_s
);

  logic [SYNC_STAGES-1:0] bclk_q, bclk_d;
  logic [SYNC_STAGES-1:0] lr_q, lr_d;
  logic [SYNC_STAGES-1:0] dat_q, dat_d;
  logic                   bclk_prev_q, bclk_prev_d;

  always_comb begin
    bclk_d      = {bclk_q[SYNC_STAGES-2:0], bclk_i};
    lr_d        = {lr_q[SYNC_STAGES-2:0], lrclk_i};
    dat_d       = {dat_q[SYNC_STAGES-2:0], adcdat_i};
    bclk_prev_d = bclk_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      bclk_q      <= '0;
      lr_q        <= '0;
      dat_q       <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_q      <= bclk_d;
      lr_q        <= lr_d;
      dat_q       <= dat_d;
      bclk_prev_q <= bclk_prev_d;
    end
  end

  assign bclk_rise = bclk_q[SYNC_STAGES-1] & ~bclk_prev_q;
  assign lr_s      = lr_q[SYNC_STAGES-1];
  assign dat_s     = dat_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: deserializes left/right words and presents stereo pairs on valid/ready.
// Define I2S_RX_OVERRUN_CNT_EN to add a saturating overrun counter (overrun_cnt_o, overrun_clr_i).
module i2s_adc_rx
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = I2S_SAMPLE_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk32,
  input  logic                rst,
  input  logic                bclk_i,
  input  logic                lrclk_i,
  input  logic                adcdat_i,
  input  logic                enable_i,
  output logic [SAMPLE_W-1:0] out_left_o,
  output logic [SAMPLE_W-1:0] out_right_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                overrun_o,
  output logic                frame_err_o
`ifdef I2S_RX_OVERRUN_CNT_EN
  ,
  input  logic                overrun_clr_i,
  output logic [15:0]         overrun_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(SAMPLE_W + 1);

  logic bclk_rise, lr_s, dat_s;

  i2s_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk32    (clk32),
    .rst      (rst),
    .bclk_i   (bclk_i),
    .lrclk_i  (lrclk_i),
    .adcdat_i (adcdat_i),
    .bclk_rise(bclk_rise),
    .lr_s     (lr_s),
    .dat_s    (dat_s)
  );

  i2s_state_e          state_q, state_d;
  logic                chan_q, chan_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic                left_ok_q, left_ok_d;
  logic                lr_prev_q, lr_prev_d;
  logic                lr_seen_q, lr_seen_d;
  logic [SAMPLE_W-1:0] out_left_q, out_left_d;
  logic [SAMPLE_W-1:0] out_right_q, out_right_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic                frame_err_q, frame_err_d;
  logic                lr_edge, pair_form;

  // No edge is reported until one LR level has been sampled since reset.
  assign lr_edge = bclk_rise & lr_seen_q & (lr_s != lr_prev_q);

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    lr_prev_d   = lr_prev_q;
    lr_seen_d   = lr_seen_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    pair_form   = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lr_s;
      lr_seen_d = 1'b1;
    end

    if (!enable_i) begin
      state_d   = StIdle;
      // A stale left word must not pair with a right word after re-enable.
      left_ok_d = 1'b0;
    end else if (bclk_rise) begin
      unique case (state_q)
        StIdle: begin
          if (lr_edge) begin
            state_d = StShift;
            chan_d  = lr_s;
            cnt_d   = '0;
          end
        end
        StShift: begin
          if (lr_edge) begin
            frame_err_d = 1'b1;
            left_ok_d   = 1'b0;
            chan_d      = lr_s;
            cnt_d       = '0;
          end else begin
            shift_d[SAMPLE_W - 1 - int'(cnt_q)] = dat_s;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(SAMPLE_W - 1)) begin
              state_d = StWait;
              if (chan_q == I2S_CH_LEFT) begin
                left_hold_d = shift_d;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                pair_form = 1'b1;
                left_ok_d = 1'b0;
              end
            end
          end
        end
        StWait: begin
          if (lr_edge) begin
            state_d = StShift;
            chan_d  = lr_s;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (pair_form) begin
      if (!out_valid_q || out_ready_i) begin
        out_left_d  = left_hold_q;
        out_right_d = shift_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      chan_q      <= I2S_CH_LEFT;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      lr_prev_q   <= 1'b0;
      lr_seen_q   <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      lr_prev_q   <= lr_prev_d;
      lr_seen_q   <= lr_seen_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_left_o  = out_left_q;
  assign out_right_o = out_right_q;
  assign out_valid_o = out_valid_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Clear has priority over a coincident overrun.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_clr_i) begin
      ovr_cnt_d = '0;
    end else if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_cnt_o = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Randomized bench for i2s_adc_rx: a pin-level codec driver plus a half-frame-level pair model.
module tb_i2s_adc_rx;

  localparam int W    = 16;
  localparam int SYNC = 2;

  logic         clk32 = 1'b0;
  logic         rst, bclk, lrclk, adcdat, enable, ready;
  logic [W-1:0] out_left, out_right;
  logic         out_valid, overrun, frame_err;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic         ovr_clr;
  logic [15:0]  ovr_cnt;
`endif

  always #5 clk32 = ~clk32;

  i2s_adc_rx #(
    .SAMPLE_W   (W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk32        (clk32),
    .rst          (rst),
    .bclk_i       (bclk),
    .lrclk_i      (lrclk),
    .adcdat_i     (adcdat),
    .enable_i     (enable),
    .out_left_o   (out_left),
    .out_right_o  (out_right),
    .out_valid_o  (out_valid),
    .out_ready_i  (ready),
    .overrun_o    (overrun),
    .frame_err_o  (frame_err)
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    .overrun_clr_i(ovr_clr),
    .overrun_cnt_o(ovr_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [2*W-1:0] exp_q[$];
  logic           model_left_ok = 1'b0;
  logic [W-1:0]   model_left = '0;
  logic           armed = 1'b0;
  logic           abandon = 1'b0;
  logic           holding = 1'b0;
  logic           ready_at_form = 1'b0;
  int             exp_ovr = 0, exp_ferr = 0, exp_cnt = 0;
  int             obs_ovr = 0, obs_ferr = 0;
  int             act_bit = -1, act_code = 0;

  task automatic tick();
    @(posedge clk32);
    #2;
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    if (!ready && holding) begin
      exp_ovr++;
      if (exp_cnt < 65535) exp_cnt++;
    end else begin
      exp_q.push_back({l, r});
      if (!ready) holding = 1'b1;
    end
  endtask

  task automatic do_action();
    if (act_code == 1) begin
      enable = 1'b1;
    end else if (act_code == 2) begin
      rst = 1'b1;
      #1;
      check_val("rst_mid_valid", out_valid, 1'b0);
      check_val("rst_mid_left", out_left, '0);
      check_val("rst_mid_right", out_right, '0);
      repeat (3) tick();
      rst           = 1'b0;
      abandon       = 1'b1;
      exp_q.delete();
      holding       = 1'b0;
      model_left_ok = 1'b0;
      exp_cnt       = 0;
    end
    act_bit = -1;
  endtask

  // One LR half-frame: edge slot, nbits data bits MSB first, random padding up to total bclks.
  task automatic half_frame(input logic ch, input logic [W-1:0] word, input int nbits,
                            input int total);
    logic cap;
    cap     = armed;
    abandon = 1'b0;
    for (int i = 0; i < total; i++) begin
      bclk   = 1'b0;
      lrclk  = ch;
      adcdat = (i >= 1 && i <= nbits && i <= W) ? word[W-i] : 1'($urandom_range(0, 1));
      repeat (3) tick();
      bclk = 1'b1;
      if (i == act_bit) do_action();
      if (cap && !abandon && i == W && nbits >= W) begin
        if (ch == 1'b0) begin
          model_left_ok = 1'b1;
          model_left    = word;
          repeat (3) tick();
        end else if (ready_at_form && model_left_ok) begin
          tick();
          tick();
          ready   = 1'b1;
          holding = 1'b0;
          push_pair(model_left, word);
          tick();
          check_val("same_cyc_valid", out_valid, 1'b1);
          check_val("same_cyc_pair", {out_left, out_right}, {model_left, word});
          check_val("same_cyc_ovr", overrun, 1'b0);
          ready_at_form = 1'b0;
          model_left_ok = 1'b0;
        end else begin
          if (model_left_ok) push_pair(model_left, word);
          model_left_ok = 1'b0;
          repeat (3) tick();
        end
      end else begin
        repeat (3) tick();
      end
    end
    if (cap && !abandon && nbits < W) begin
      exp_ferr++;
      model_left_ok = 1'b0;
    end
    armed = enable;
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r);
    half_frame(1'b0, l, W, 32);
    half_frame(1'b1, r, W, 32);
  endtask

  // Monitor: transfers, stall stability, pulse counts
  initial begin
    logic           stall_prev;
    logic [2*W-1:0] stall_data;
    logic [2*W-1:0] p;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk32);
      if (overrun) obs_ovr++;
      if (frame_err) obs_ferr++;
      if (stall_prev && out_valid) check_val("stall_stable", {out_left, out_right}, stall_data);
      if (out_valid && ready) begin
        check_val("xfer_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          check_val("xfer_left", out_left, p[2*W-1:W]);
          check_val("xfer_right", out_right, p[W-1:0]);
        end
      end
      stall_prev = out_valid && !ready;
      stall_data = {out_left, out_right};
    end
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    ready  = 1'b1;
    bclk   = 1'b0;
    lrclk  = 1'b0;
    adcdat = 1'b0;
`ifdef I2S_RX_OVERRUN_CNT_EN
    ovr_clr = 1'b0;
`endif
    repeat (3) tick();
    check_val("rst_valid", out_valid, 1'b0);
    check_val("rst_left", out_left, '0);
    check_val("rst_right", out_right, '0);
    check_val("rst_ovr", overrun, 1'b0);
    check_val("rst_ferr", frame_err, 1'b0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check_val("rst_cnt", ovr_cnt, 16'd0);
`endif
    rst = 1'b0;
    tick();

    // Enable mid right word; the partial half-frame is never captured
    half_frame(1'b0, 16'($urandom), W, 32);
    act_bit  = 8;
    act_code = 1;
    half_frame(1'b1, 16'($urandom), W, 32);
    repeat (3) frame(16'h8001, 16'h7FFE);
    check_val("drain_fixed", exp_q.size(), 0);

    repeat (4) frame(16'($urandom), 16'($urandom));
    check_val("drain_rand", exp_q.size(), 0);

    // Consumer stalled across three frames
    ready = 1'b0;
    frame(16'h0001, 16'hFFFF);
    frame(16'h0002, 16'hFFFE);
    frame(16'h0003, 16'hFFFD);
    check_val("stall_ovr_cnt", obs_ovr, exp_ovr);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check_val("ovr_cnt", ovr_cnt, exp_cnt);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_cnt = 0;
    check_val("ovr_cnt_clr", ovr_cnt, exp_cnt);
`endif
    ready   = 1'b1;
    holding = 1'b0;
    repeat (4) tick();
    check_val("drain_stall", exp_q.size(), 0);

    // Ready rises in the exact cycle a new pair forms while one is held
    ready = 1'b0;
    frame(16'($urandom), 16'($urandom));
    ready_at_form = 1'b1;
    frame(16'($urandom), 16'($urandom));
    check_val("same_cyc_ovr_total", obs_ovr, exp_ovr);
    check_val("drain_same_cyc", exp_q.size(), 0);

    // Short left word
    half_frame(1'b0, 16'($urandom), 9, 10);
    half_frame(1'b1, 16'($urandom), W, 32);
    frame(16'($urandom), 16'($urandom));
    check_val("ferr_count", obs_ferr, exp_ferr);
    check_val("drain_ferr", exp_q.size(), 0);

    // Reset mid right word while a pair is held
    ready = 1'b0;
    frame(16'($urandom), 16'($urandom));
    half_frame(1'b0, 16'($urandom), W, 32);
    act_bit  = 8;
    act_code = 2;
    half_frame(1'b1, 16'($urandom), W, 32);
    ready = 1'b1;
    repeat (2) frame(16'($urandom), 16'($urandom));
`ifdef I2S_RX_OVERRUN_CNT_EN
    check_val("post_rst_cnt", ovr_cnt, exp_cnt);
`endif

    repeat (20) tick();
    check_val("final_drain", exp_q.size(), 0);
    check_val("final_ovr", obs_ovr, exp_ovr);
    check_val("final_ferr", obs_ferr, exp_ferr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
- Receives I2S serial ADC data from the WM8750 codec (codec_adcdata) and deserializes it into signed 16-bit left/right sample pairs.
- The codec clocks (bit clock, ADC LR clock) are generated by the existing audio output path. This block oversamples them in the clk32 system domain.
- Complete stereo pairs are presented to the SoC audio capture logic on a valid/ready interface, with overrun detection.

Parameters:
- SAMPLE_W, 16, captured bits per channel, MSB first. Range 8..24.
- SYNC_STAGES, 2, synchronizer flops on bclk_i, lrclk_i and adcdat_i. Minimum 2.

Ports:
- clk32  input  1  system clock. Must be at least 4x the bclk_i frequency.
- rst  input  1  reset, asynchronous, active-high.
- bclk_i  input  1  codec bit clock. Asynchronous to clk32.
- lrclk_i  input  1  codec ADC LR clock. 0 = left channel, 1 = right channel.
- adcdat_i  input  1  codec serial ADC data.
- enable_i  input  1  capture enable. While 0, the FSM is held in IDLE.
- out_left_o  output  SAMPLE_W  left sample, signed.
- out_right_o  output  SAMPLE_W  right sample, signed.
- out_valid_o  output  1  a stereo pair is held on out_left_o/out_right_o.
- out_ready_i  input  1  consumer accepts the pair.
- overrun_o  output  1  one-cycle pulse when a completed pair is dropped.
- frame_err_o  output  1  one-cycle pulse on a short channel (LR edge before SAMPLE_W bits were captured).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; shift register, bit counter and left holding register cleared.
- Input sync: bclk_i, lrclk_i and adcdat_i each pass through SYNC_STAGES flops.
- Edge detect: one extra register on synced bclk. bclk_rise = synced bclk 0->1. All capture actions occur only in clk32 cycles where bclk_rise=1.
- Latency: a pin change is acted on SYNC_STAGES+1 clk32 cycles later.
- LR edge: lr_edge = sampled LR level at bclk_rise differs from the LR level at the previous bclk_rise.
- I2S format: the MSB arrives on the first bclk rise after an LR edge. The bit coincident with the edge is the LSB slot of the previous word and is ignored. Bits after SAMPLE_W until the next LR edge are ignored.
- FSM (all transitions evaluated at bclk_rise):
  - IDLE: wait for enable_i=1 and an lr_edge, then go to SHIFT with chan = new LR level and bit count 0. The first partial half-frame after enable is never captured.
  - SHIFT: shift in adcdat, bit count +1. When count reaches SAMPLE_W, commit the channel and go to WAIT.
    - lr_edge in SHIFT before SAMPLE_W bits: pulse frame_err_o, discard the partial word, restart SHIFT for the new channel at count 0.
  - WAIT: on lr_edge, go to SHIFT for the new channel.
  - enable_i=0 in any state: go to IDLE next clk32 cycle. out_valid_o and the held pair are unaffected.
- Commit left: write the left holding register, set left_ok.
- Commit right:
  - left_ok=1: form the pair {left hold, right word} and clear left_ok.
  - left_ok=0: discard the right word silently; no pair is formed.
- Handshake, on the cycle a pair is formed:
  - out_valid_o=0: load outputs, set out_valid_o.
  - out_valid_o=1 and out_ready_i=1: load the new pair, out_valid_o stays 1.
  - out_valid_o=1 and out_ready_i=0: keep the old pair, drop the new one, pulse overrun_o.
- When no pair is formed, out_ready_i=1 with out_valid_o=1 clears out_valid_o next cycle.
- Output data is stable while out_valid_o=1 and out_ready_i=0.
- Frame error also clears left_ok.
- Reset mid-word: all state is abandoned; resynchronization starts at the first lr_edge after reset release.

Optional Feature:
- Macro: I2S_RX_OVERRUN_CNT_EN.
- Defined: adds output overrun_cnt_o [15:0], a saturating count of overrun_o pulses (sticks at 16'hFFFF). It is cleared by rst or by a one-cycle input overrun_clr_i. If a clear and an overrun occur in the same cycle, the clear wins and the count is 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package i2s_pkg holds:
  - FSM state encoding (IDLE, SHIFT, WAIT), shared with a future transmitter.
  - Constants I2S_CH_LEFT=0 and I2S_CH_RIGHT=1.
  - The default SAMPLE_W.
- One sub-module, i2s_sync_edge: SYNC_STAGES synchronizer for the three inputs plus the bclk rising-edge detector. Outputs bclk_rise, lr_s and dat_s.

Test Plan:
- Codec model at bclk = 64x fs, 32 bclk per half-frame, sending L=16'h8001, R=16'h7FFE, out_ready_i=1 -> after sync, out_left_o=16'h8001, out_right_o=16'h7FFE, one valid cycle per frame. The first partial frame is not reported.
- out_ready_i held 0 across 3 frames (L=1..3, R=-1..-3) -> pair (1,-1) held stable; overrun_o pulses twice; counter reads 2 with I2S_RX_OVERRUN_CNT_EN.
- LR toggles after 9 bits of a left word -> frame_err_o pulses once. The following right word is not paired; the next full frame yields a correct pair.
- Enable asserted with LR currently right, mid-word -> no output until a full left+right sequence; the first pair equals the second frame's data.
- rst asserted for 3 clk32 cycles mid-right-word with out_valid_o=1 -> all outputs 0 immediately; next valid pair is from a complete post-reset frame.
- out_ready_i=1 in the same cycle a new pair forms while out_valid_o=1 -> new pair loaded, out_valid_o stays 1, no overrun_o pulse.
